tdc_meas_ctrl: RTL and testbench

Measurement sequencer for the tapped-delay-line TDC. The block arms the delay line, waits for a synchronized start event, and launches the start edge into the chain. After a programmable settle interval it strobes the tap capture, then encodes the captured thermometer word into a binary count with status flags. It sits between the chip pins (`ui_in`) and the delay-line module, and presents a held result to the output mux under a valid/ack handshake.

---
 rtl/tdc_meas_ctrl_if.sv | 27 ++
 rtl/tdc_meas_ctrl.sv | 256 +++++++++++++++++++++++++
 tb/tb_tdc_meas_ctrl.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/tdc_meas_ctrl_if.sv
// ============================================================================
// tdc_meas_ctrl_if : result handshake between the TDC sequencer and output mux
// Revision: 1.0
// ============================================================================
`default_nettype none

interface tdc_meas_ctrl_if;
    logic [7:0] result;
    logic       valid;
    logic       ack;
    logic       busy;
    logic       overflow;
    logic       bubble;
    logic       timeout;

    modport master (
        output result, valid, busy, overflow, bubble, timeout,
        input  ack
    );

    modport slave (
        input  result, valid, busy, overflow, bubble, timeout,
        output ack
    );
endinterface

`default_nettype wire

// File: rtl/tdc_meas_ctrl.sv
// ============================================================================
// tdc_meas_ctrl : arm / start / settle / capture / encode sequencer for the
//                 tapped-delay-line TDC. Optional 4-pass averaging: TDC_MEAS_AVG_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tdc_meas_ctrl #(
    parameter int N_DELAY        = 16,
    parameter int SETTLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  wire                clk,
    input  wire                rst_n,
    input  wire                arm,
    input  wire                start_in,
    output logic               tdc_rst_n,
    output logic               tdc_start,
    output logic               tdc_sample,
    input  wire  [N_DELAY-1:0] taps,
    tdc_meas_ctrl_if.master    res_if
);

    localparam int          POP_W        = $clog2(N_DELAY + 1);
    localparam logic [15:0] SETTLE_LAST  = 16'(SETTLE_CYCLES - 1);
    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);
    localparam logic [N_DELAY-1:0] TAP_ONE = {{(N_DELAY-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ARMED   = 3'd1,
        ST_RUN     = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_ENCODE  = 3'd4,
        ST_DONE    = 3'd5
`ifdef TDC_MEAS_AVG_EN
        , ST_GAP   = 3'd6
`endif
    } state_t;

    state_t             state_q, state_d;
    logic [15:0]        cnt_q, cnt_d;
    logic [N_DELAY-1:0] tap_q, tap_d;
    logic [7:0]         result_q, result_d;
    logic               overflow_q, overflow_d;
    logic               bubble_q, bubble_d;
    logic               timeout_q, timeout_d;
    logic               valid_q, valid_d;
    logic               busy_q, busy_d;
    logic               tdc_rst_n_q, tdc_rst_n_d;
    logic               tdc_start_q, tdc_start_d;
    logic               tdc_sample_q, tdc_sample_d;
    logic               sync1_q, sync2_q, sync3_q;
    logic               start_rise;

`ifdef TDC_MEAS_AVG_EN
    logic [1:0]         pass_q, pass_d;
    logic [9:0]         sum_q, sum_d;
    logic               ovf_acc_q, ovf_acc_d;
    logic               bub_acc_q, bub_acc_d;
`endif

    logic [POP_W-1:0]   pop_w;
    logic [N_DELAY-1:0] tap_inc_w;
    logic               full_w;
    logic               bub_w;

    function automatic logic [POP_W-1:0] popcount(input logic [N_DELAY-1:0] v);
        logic [POP_W-1:0] c;
        c = '0;
        for (int i = 0; i < N_DELAY; i++) begin
            c = c + POP_W'(v[i]);
        end
        return c;
    endfunction

    // A clean thermometer code is 0...01...1; adding one to it clears every set bit.
    assign pop_w     = popcount(tap_q);
    assign tap_inc_w = tap_q + TAP_ONE;
    assign full_w    = &tap_q;
    assign bub_w     = |(tap_q & tap_inc_w);

    assign start_rise = sync2_q & ~sync3_q;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        tap_d      = tap_q;
        result_d   = result_q;
        overflow_d = overflow_q;
        bubble_d   = bubble_q;
        timeout_d  = timeout_q;
`ifdef TDC_MEAS_AVG_EN
        pass_d     = pass_q;
        sum_d      = sum_q;
        ovf_acc_d  = ovf_acc_q;
        bub_acc_d  = bub_acc_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (arm) begin
                    state_d    = ST_ARMED;
                    cnt_d      = '0;
                    result_d   = '0;
                    overflow_d = 1'b0;
                    bubble_d   = 1'b0;
                    timeout_d  = 1'b0;
`ifdef TDC_MEAS_AVG_EN
                    pass_d     = '0;
                    sum_d      = '0;
                    ovf_acc_d  = 1'b0;
                    bub_acc_d  = 1'b0;
`endif
                end
            end
            ST_ARMED: begin
                // A start arriving on the expiry cycle takes priority over the abort.
                if (start_rise) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    state_d   = ST_DONE;
                    timeout_d = 1'b1;
                    result_d  = '0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            ST_RUN: begin
                if (cnt_q == SETTLE_LAST) begin
                    state_d = ST_CAPTURE;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            ST_CAPTURE: begin
                tap_d   = taps;
                state_d = ST_ENCODE;
            end
            ST_ENCODE: begin
`ifdef TDC_MEAS_AVG_EN
                sum_d     = sum_q + 10'(pop_w);
                ovf_acc_d = ovf_acc_q | full_w;
                bub_acc_d = bub_acc_q | bub_w;
                if (pass_q == 2'd3) begin
                    state_d    = ST_DONE;
                    result_d   = sum_d[9:2];
                    overflow_d = ovf_acc_d;
                    bubble_d   = bub_acc_d;
                end else begin
                    state_d = ST_GAP;
                    pass_d  = pass_q + 2'd1;
                end
`else
                state_d    = ST_DONE;
                result_d   = 8'(pop_w);
                overflow_d = full_w;
                bubble_d   = bub_w;
`endif
            end
`ifdef TDC_MEAS_AVG_EN
            ST_GAP: begin
                state_d = ST_ARMED;
                cnt_d   = '0;
            end
`endif
            ST_DONE: begin
                if (res_if.ack) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Strobes are decoded from the next state so they register with it.
        busy_d       = (state_d != ST_IDLE);
        valid_d      = (state_d == ST_DONE);
        tdc_sample_d = (state_d == ST_CAPTURE);
        tdc_start_d  = (state_d == ST_RUN) || (state_d == ST_CAPTURE) ||
                       (state_d == ST_ENCODE);
        tdc_rst_n_d  = (state_d != ST_IDLE);
`ifdef TDC_MEAS_AVG_EN
        if (state_d == ST_GAP) begin
            tdc_rst_n_d = 1'b0;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            tap_q        <= '0;
            result_q     <= '0;
            overflow_q   <= 1'b0;
            bubble_q     <= 1'b0;
            timeout_q    <= 1'b0;
            valid_q      <= 1'b0;
            busy_q       <= 1'b0;
            tdc_rst_n_q  <= 1'b0;
            tdc_start_q  <= 1'b0;
            tdc_sample_q <= 1'b0;
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            sync3_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            tap_q        <= tap_d;
            result_q     <= result_d;
            overflow_q   <= overflow_d;
            bubble_q     <= bubble_d;
            timeout_q    <= timeout_d;
            valid_q      <= valid_d;
            busy_q       <= busy_d;
            tdc_rst_n_q  <= tdc_rst_n_d;
            tdc_start_q  <= tdc_start_d;
            tdc_sample_q <= tdc_sample_d;
            sync1_q      <= start_in;
            sync2_q      <= sync1_q;
            sync3_q      <= sync2_q;
        end
    end

`ifdef TDC_MEAS_AVG_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pass_q    <= '0;
            sum_q     <= '0;
            ovf_acc_q <= 1'b0;
            bub_acc_q <= 1'b0;
        end else begin
            pass_q    <= pass_d;
            sum_q     <= sum_d;
            ovf_acc_q <= ovf_acc_d;
            bub_acc_q <= bub_acc_d;
        end
    end
`endif

    assign tdc_rst_n       = tdc_rst_n_q;
    assign tdc_start       = tdc_start_q;
    assign tdc_sample      = tdc_sample_q;
    assign res_if.result   = result_q;
    assign res_if.valid    = valid_q;
    assign res_if.busy     = busy_q;
    assign res_if.overflow = overflow_q;
    assign res_if.bubble   = bubble_q;
    assign res_if.timeout  = timeout_q;

endmodule

`default_nettype wire

// File: tb/tb_tdc_meas_ctrl.sv
// ============================================================================
// tb_tdc_meas_ctrl : randomized bench for tdc_meas_ctrl against a behavioural
//                    model of popcount, thermometer cleanliness and latencies.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_tdc_meas_ctrl;

    localparam int N_DELAY        = 16;
    localparam int SETTLE_CYCLES  = 4;
    localparam int TIMEOUT_CYCLES = 255;

    localparam int LAT_START  = 3;
    localparam int LAT_SAMPLE = LAT_START + SETTLE_CYCLES;
    localparam int LAT_VALID  = LAT_SAMPLE + 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        arm;
    logic        start_in;
    logic [15:0] taps;
    logic        tdc_rst_n;
    logic        tdc_start;
    logic        tdc_sample;

    int n_checks = 0;
    int n_fail   = 0;

    tdc_meas_ctrl_if res_if ();

    tdc_meas_ctrl #(
        .N_DELAY        (N_DELAY),
        .SETTLE_CYCLES  (SETTLE_CYCLES),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .arm        (arm),
        .start_in   (start_in),
        .tdc_rst_n  (tdc_rst_n),
        .tdc_start  (tdc_start),
        .tdc_sample (tdc_sample),
        .taps       (taps),
        .res_if     (res_if)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int model_count(input logic [15:0] w);
        int c = 0;
        for (int i = 0; i < 16; i++) if (w[i]) c++;
        return c;
    endfunction

    // Dirty if, scanning upward from bit 0, any set bit follows a clear bit.
    function automatic int model_bubble(input logic [15:0] w);
        bit seen_clear = 0;
        for (int i = 0; i < 16; i++) begin
            if (!w[i]) seen_clear = 1;
            else if (seen_clear) return 1;
        end
        return 0;
    endfunction

    task automatic measure(input logic [15:0] t, input int dly, input int hold, input bit ack_with_arm);
        int n, first_start, first_sample, n_sample;
        logic [7:0] held;
        bit stable;
        taps = t;
        arm  = 1'b1;
        step();
        arm  = 1'b0;
        check_eq("busy_after_arm", int'(res_if.busy), 1);
        check_eq("tdc_rst_n_armed", int'(tdc_rst_n), 1);
        repeat (dly) step();
        start_in     = 1'b1;
        n            = 0;
        first_start  = -1;
        first_sample = -1;
        n_sample     = 0;
        while (n < 40 && !res_if.valid) begin
            step();
            n++;
            if (tdc_start && first_start < 0) first_start = n;
            if (tdc_sample) begin
                n_sample++;
                if (first_sample < 0) first_sample = n;
            end
        end
        check_eq("valid_seen", int'(res_if.valid), 1);
        check_eq("valid_latency", n, LAT_VALID);
        check_eq("start_latency", first_start, LAT_START);
        check_eq("sample_latency", first_sample, LAT_SAMPLE);
        check_eq("sample_width", n_sample, 1);
        check_eq("tdc_start_done", int'(tdc_start), 0);
        check_eq("result", int'(res_if.result), model_count(t));
        check_eq("overflow", int'(res_if.overflow), (t == 16'hFFFF) ? 1 : 0);
        check_eq("bubble", int'(res_if.bubble), model_bubble(t));
        check_eq("timeout_clear", int'(res_if.timeout), 0);
        held   = res_if.result;
        stable = 1;
        for (int i = 0; i < hold; i++) begin
            arm = (i == hold / 2);
            step();
            if (!res_if.valid || res_if.result != held) stable = 0;
        end
        arm = 1'b0;
        check_eq("held_stable", int'(stable), 1);
        res_if.ack = 1'b1;
        arm        = ack_with_arm;
        step();
        res_if.ack = 1'b0;
        arm        = 1'b0;
        start_in   = 1'b0;
        check_eq("valid_after_ack", int'(res_if.valid), 0);
        check_eq("busy_after_ack", int'(res_if.busy), 0);
        repeat (3) step();
        check_eq("idle_stays", int'(res_if.busy), 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: observed no finish expected finish");
        $fatal(1);
    end

    initial begin
        int n;
        bit saw_start;
        logic [15:0] t;
        rst_n      = 1'b0;
        arm        = 1'b0;
        start_in   = 1'b0;
        taps       = '0;
        res_if.ack = 1'b0;
        repeat (3) step();
        check_eq("rst_tdc_rst_n", int'(tdc_rst_n), 0);
        check_eq("rst_tdc_start", int'(tdc_start), 0);
        check_eq("rst_tdc_sample", int'(tdc_sample), 0);
        check_eq("rst_valid", int'(res_if.valid), 0);
        check_eq("rst_busy", int'(res_if.busy), 0);
        check_eq("rst_result", int'(res_if.result), 0);
        check_eq("rst_flags", int'({res_if.overflow, res_if.bubble, res_if.timeout}), 0);
        rst_n = 1'b1;
        repeat (2) step();

        measure(16'h00FF, 2, 20, 1'b0);
        measure(16'hFFFF, 0, 3, 1'b0);
        measure(16'h00F7, 5, 2, 1'b1);
        measure(16'h0000, 1, 1, 1'b0);

        // Timeout with no start edge
        arm = 1'b1;
        step();
        arm       = 1'b0;
        n         = 0;
        saw_start = 0;
        while (n < 400 && !res_if.valid) begin
            step();
            n++;
            if (tdc_start) saw_start = 1;
        end
        check_eq("to_valid", int'(res_if.valid), 1);
        check_eq("to_latency", n, TIMEOUT_CYCLES);
        check_eq("to_flag", int'(res_if.timeout), 1);
        check_eq("to_result", int'(res_if.result), 0);
        check_eq("to_no_start", int'(saw_start), 0);
        res_if.ack = 1'b1;
        step();
        res_if.ack = 1'b0;
        check_eq("to_busy_after_ack", int'(res_if.busy), 0);
        repeat (3) step();

        // Asynchronous reset while the chain is running
        taps = 16'h0FFF;
        arm  = 1'b1;
        step();
        arm      = 1'b0;
        start_in = 1'b1;
        repeat (LAT_START + 1) step();
        check_eq("run_tdc_start", int'(tdc_start), 1);
        #2 rst_n = 1'b0;
        #1;
        check_eq("arst_tdc_start", int'(tdc_start), 0);
        check_eq("arst_busy", int'(res_if.busy), 0);
        check_eq("arst_tdc_rst_n", int'(tdc_rst_n), 0);
        check_eq("arst_valid", int'(res_if.valid), 0);
        start_in = 1'b0;
        repeat (2) step();
        rst_n = 1'b1;
        repeat (3) step();
        measure(16'h0FFF, 3, 2, 1'b0);

        for (int k = 0; k < 20; k++) begin
            case ($urandom_range(0, 2))
                0: begin
                    n = $urandom_range(0, 16);
                    t = 16'(((32'd1 << n) - 32'd1));
                end
                1:       t = 16'($urandom);
                default: t = ($urandom_range(0, 1) != 0) ? 16'hFFFF : 16'h0000;
            endcase
            measure(t, $urandom_range(0, 30), $urandom_range(0, 6), 1'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
